pow2_mul_arbiter: RTL and testbench

- Shares one pipelined 8x8 unsigned squaring multiplier (P = A*A) between NUM_REQ requesters using round-robin arbitration.
- Accepts at most one operand per cycle and drives it to the multiplier.
- Tracks requester IDs through a tag pipeline matched to the multiplier latency, and returns each 16-bit result tagged with its requester ID.
- Sits between the requesting datapath blocks and the squaring multiplier core.

---
 rtl/pow2_mul_arbiter.sv | 126 ++++++++++++
 tb/tb_pow2_mul_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pow2_mul_arbiter.sv
// pow2_mul_arbiter: round-robin sharing of one pipelined 8x8 squaring multiplier.
// Optional per-requester grant counters when POW2_MUL_ARB_STATS_EN is defined.
module pow2_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    arb_en_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ*8-1:0]    req_data_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic [7:0]              mul_a_o,
    input  logic [15:0]             mul_p_i,
    output logic                    res_valid_o,
    output logic [ID_W-1:0]         res_id_o,
    output logic [15:0]             res_data_o,
    output logic                    busy_o,
    input  logic                    stats_clr_i,
    output logic [NUM_REQ*16-1:0]   grant_cnt_o
);

    typedef struct packed {
        logic            v;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W:0]   cand;
    logic            gnt_any;
    logic [ID_W-1:0] gnt_id;
    logic [7:0]      gnt_data;
    tag_t            tag_q [MUL_LAT];
    logic            tag_any;

    // Search starts one past the last winner and wraps at NUM_REQ.
    always_comb begin
        cand    = '0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!gnt_any && req_valid_i[cand[ID_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = cand[ID_W-1:0];
            end
        end
        gnt_any = gnt_any & arb_en_i;
    end

    assign req_ready_o = gnt_any ? (NUM_REQ'(1) << gnt_id) : '0;
    assign gnt_data    = req_data_i[{gnt_id, 3'b000} +: 8];

    always_comb begin
        tag_any = 1'b0;
        for (int i = 0; i < MUL_LAT; i++) begin
            tag_any = tag_any | tag_q[i].v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_o     <= '0;
            rr_ptr      <= ID_W'(NUM_REQ - 1);
            res_valid_o <= 1'b0;
            res_id_o    <= '0;
            res_data_o  <= '0;
            busy_o      <= 1'b0;
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            if (gnt_any) begin
                mul_a_o <= gnt_data;
                rr_ptr  <= gnt_id;
            end
            tag_q[0] <= {gnt_any, gnt_id};
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            res_valid_o <= tag_q[MUL_LAT-1].v;
            if (tag_q[MUL_LAT-1].v) begin
                res_id_o   <= tag_q[MUL_LAT-1].id;
                res_data_o <= mul_p_i;
            end
            busy_o <= tag_any | res_valid_o;
        end
    end

`ifdef POW2_MUL_ARB_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];

    // Clear wins over a same-cycle grant; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (stats_clr_i) begin
                    cnt_q[i] <= '0;
                end else if (req_ready_o[i] && cnt_q[i] != 16'hFFFF) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt_o[16*i +: 16] = cnt_q[i];
        end
    end
`else
    logic unused_stats;
    assign unused_stats = stats_clr_i;
    assign grant_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pow2_mul_arbiter.sv
// tb_pow2_mul_arbiter: directed and random checks against a transaction-level model.
// Counter checks follow the POW2_MUL_ARB_STATS_EN build.
module tb_pow2_mul_arbiter;

    localparam int N   = 4;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          arb_en_i = 1'b0;
    logic [N-1:0]  req_valid_i = '0;
    logic [N*8-1:0] req_data_i = '0;
    logic [N-1:0]  req_ready_o;
    logic [7:0]    mul_a_o;
    logic [15:0]   mul_p_i;
    logic          res_valid_o;
    logic [1:0]    res_id_o;
    logic [15:0]   res_data_o;
    logic          busy_o;
    logic          stats_clr_i = 1'b0;
    logic [N*16-1:0] grant_cnt_o;

    pow2_mul_arbiter #(.NUM_REQ(N), .ID_W(2), .MUL_LAT(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arb_en_i    (arb_en_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .mul_a_o     (mul_a_o),
        .mul_p_i     (mul_p_i),
        .res_valid_o (res_valid_o),
        .res_id_o    (res_id_o),
        .res_data_o  (res_data_o),
        .busy_o      (busy_o),
        .stats_clr_i (stats_clr_i),
        .grant_cnt_o (grant_cnt_o)
    );

    always #5 clk = ~clk;

    // Squaring core: product of the operand driven LAT-1 edges earlier.
    logic [7:0] a_d1 = '0;
    logic [7:0] a_d2 = '0;
    always @(posedge clk) begin
        a_d1 <= mul_a_o;
        a_d2 <= a_d1;
    end
    assign mul_p_i = {8'd0, a_d2} * {8'd0, a_d2};

    int total = 0;
    int bad = 0;
    int edge_n = 0;
    int rr = N - 1;
    bit hs_v [int];
    int hs_id [int];
    int hs_d [int];
    int exp_id = 0;
    int exp_dat = 0;
    int last_a = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_grant();
        int c;
        if (!arb_en_i) return -1;
        for (int k = 1; k <= N; k++) begin
            c = (rr + k) % N;
            if (req_valid_i[2'(c)]) return c;
        end
        return -1;
    endfunction

    task automatic tick();
        int g;
        int d;
        int m;
        bit exp_rv;
        bit exp_busy;
        #1;
        g = exp_grant();
        d = (g >= 0) ? int'(req_data_i[8*g +: 8]) : 0;
        chk("ready", 32'(req_ready_o), (g < 0) ? 32'd0 : 32'(1 << g));
        @(posedge clk);
        edge_n++;
        if (g >= 0) begin
            hs_v[edge_n]  = 1'b1;
            hs_id[edge_n] = g;
            hs_d[edge_n]  = d;
            rr = g;
            last_a = d;
        end
        #1;
        m = edge_n;
        exp_rv = hs_v.exists(m - LAT) != 0;
        if (exp_rv) begin
            exp_id  = hs_id[m - LAT];
            exp_dat = hs_d[m - LAT] * hs_d[m - LAT];
        end
        exp_busy = 1'b0;
        for (int n = m - LAT - 1; n <= m - 1; n++) begin
            if (hs_v.exists(n) != 0) exp_busy = 1'b1;
        end
        chk("res_valid", 32'(res_valid_o), 32'(exp_rv));
        chk("res_id", 32'(res_id_o), exp_id);
        chk("res_data", 32'(res_data_o), exp_dat);
        chk("busy", 32'(busy_o), 32'(exp_busy));
        chk("mul_a", 32'(mul_a_o), last_a);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_res_valid", 32'(res_valid_o), 0);
        chk("rst_res_id", 32'(res_id_o), 0);
        chk("rst_res_data", 32'(res_data_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_mul_a", 32'(mul_a_o), 0);
        rr = N - 1;
        hs_v.delete();
        hs_id.delete();
        hs_d.delete();
        exp_id = 0;
        exp_dat = 0;
        last_a = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // single request from requester 2
        arb_en_i = 1'b1;
        req_data_i = 32'h000F_0000;
        req_valid_i = 4'b0100;
        tick();
        req_valid_i = '0;
        repeat (6) tick();

        // all requesters valid, round robin from 0
        do_reset();
        req_data_i = 32'hFF03_0201;
        req_valid_i = '1;
        repeat (8) tick();
        req_valid_i = '0;
        repeat (6) tick();

        // grant enable dropped with requests held
        req_valid_i = '1;
        repeat (2) tick();
        arb_en_i = 1'b0;
        repeat (8) tick();
        arb_en_i = 1'b1;

        // reset with operations in flight
        repeat (3) tick();
        do_reset();
        repeat (6) tick();
        req_valid_i = '0;
        repeat (5) tick();

        // requesters 1 and 3, then 0 joins
        do_reset();
        req_data_i = 32'h4433_2211;
        req_valid_i = 4'b1010;
        repeat (4) tick();
        tick();
        req_valid_i = 4'b1011;
        tick();
        tick();
        req_valid_i = '0;
        repeat (5) tick();

        // random traffic
        repeat (300) begin
            req_valid_i = 4'($urandom);
            req_data_i = $urandom;
            arb_en_i = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 49) == 0) do_reset();
            tick();
        end
        req_valid_i = '0;
        arb_en_i = 1'b1;
        repeat (6) tick();

`ifdef POW2_MUL_ARB_STATS_EN
        do_reset();
        req_valid_i = 4'b0001;
        repeat (70000) @(posedge clk);
        #1;
        chk("cnt_sat", 32'(grant_cnt_o[15:0]), 32'h0000_FFFF);
        chk("cnt_other", 32'(grant_cnt_o[31:16]), 0);
        stats_clr_i = 1'b1;
        @(posedge clk);
        #1;
        stats_clr_i = 1'b0;
        chk("cnt_clr", 32'(grant_cnt_o[15:0]), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("cnt_after_clr", 32'(grant_cnt_o[15:0]), 3);
        req_valid_i = '0;
`else
        chk("cnt_off_lo", grant_cnt_o[31:0], 0);
        chk("cnt_off_hi", grant_cnt_o[63:32], 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
